// File: rtl/cmd_ring_pkg.sv
// cmd_ring_pkg: shared types and constants for the command-ring streamer.
package cmd_ring_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_WB_REQ,
    S_ERROR
  } state_e;

  localparam logic [31:0] CMD_WORD_BYTES = 32'd4;
  localparam logic [1:0]  ALIGN_MASK     = 2'b11;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/cmd_word_fifo.sv
// cmd_word_fifo: first-word-fall-through FIFO of command words.
// Push into a full FIFO is accepted only alongside a pop.
module cmd_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;
  logic          do_push;

  assign empty    = count == '0;
  assign full     = count == (AW+1)'(DEPTH);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cmd_ring_streamer.sv
// cmd_ring_streamer: command-ring consumer with pointer writeback.
// Optional perf counters are built when CMD_RING_STREAMER_PERF_EN is defined.
module cmd_ring_streamer
  import cmd_ring_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_enable,
  input  logic [31:0]       cmd_ring_base,
  input  logic [31:0]       cmd_ring_size_bytes,
  input  logic [31:0]       cmd_cons_ptr_bytes,
  input  logic [31:0]       cmd_completion_base,
  input  logic              doorbell_valid,
  input  logic [31:0]       doorbell_prod_ptr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [31:0]       cmd_data,
  output logic              busy,
  output logic [31:0]       cons_ptr_out,
  output logic              err,
  output logic [31:0]       perf_cmd_count,
  output logic [31:0]       perf_stall_cycles
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state;
  logic          en_q;
  logic          en_rise;
  logic          active;
  logic          fault;
  logic          drop;
  logic [31:0]   cons;
  logic [31:0]   prod;
  logic [31:0]   last_wb;
  logic [31:0]   cons_nxt;
  logic          cfg_bad;
  logic          db_take;
  logic          db_bad;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign en_rise = cmd_enable & ~en_q;
  assign active  = cmd_enable & en_q;

  assign cfg_bad = misaligned(cmd_ring_base[1:0])
                 | (cmd_ring_size_bytes == '0)
                 | misaligned(cmd_ring_size_bytes[1:0])
                 | (cmd_cons_ptr_bytes >= cmd_ring_size_bytes)
                 | misaligned(cmd_cons_ptr_bytes[1:0]);

  assign db_take = doorbell_valid & active & ~fault
                 & (state != S_ERROR);
  assign db_bad  = (doorbell_prod_ptr >= cmd_ring_size_bytes)
                 | misaligned(doorbell_prod_ptr[1:0]);

  assign cons_nxt =
    (cons + CMD_WORD_BYTES == cmd_ring_size_bytes) ?
    '0 : cons + CMD_WORD_BYTES;

  // a response seen after a disable belongs to a dead ring
  assign push = (state == S_FETCH_WAIT) & mem_rsp_valid
              & active & ~drop;
  assign pop  = cmd_valid & cmd_ready;

  assign cmd_valid     = ~fifo_empty;
  assign mem_req_valid = (state == S_FETCH_REQ)
                       | (state == S_WB_REQ);
  assign err           = state == S_ERROR;
  assign busy          = (state != S_IDLE) | (fifo_count != '0);
  assign cons_ptr_out  = cons;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      en_q          <= 1'b0;
      fault         <= 1'b0;
      drop          <= 1'b0;
      cons          <= '0;
      prod          <= '0;
      last_wb       <= '0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      en_q <= cmd_enable;
      if (push) cons <= cons_nxt;
      if (db_take && !db_bad) prod <= doorbell_prod_ptr;
      if (!cmd_enable) fault <= 1'b0;
      else if (db_take && db_bad) fault <= 1'b1;

      case (state)
        S_IDLE: begin
          drop <= 1'b0;
          if (fault && cmd_enable) begin
            state <= S_ERROR;
          end else if (active && cons != prod
                       && !fifo_full) begin
            state        <= S_FETCH_REQ;
            mem_req_we   <= 1'b0;
            mem_req_addr <= ADDR_W'(cmd_ring_base + cons);
          end else if (active && cons == prod
                       && cons != last_wb) begin
            state         <= S_WB_REQ;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= ADDR_W'(cmd_completion_base);
            mem_req_wdata <= cons;
          end
        end
        S_FETCH_REQ: begin
          if (!cmd_enable) drop <= 1'b1;
          if (mem_req_ready) state <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          if (!cmd_enable) drop <= 1'b1;
          if (mem_rsp_valid) state <= S_IDLE;
        end
        S_WB_REQ: begin
          if (mem_req_ready) begin
            last_wb <= cons;
            state   <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (!cmd_enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // enable rise overrides any pointer update above
      if (en_rise) begin
        cons    <= cmd_cons_ptr_bytes;
        prod    <= cmd_cons_ptr_bytes;
        last_wb <= cmd_cons_ptr_bytes;
        fault   <= cfg_bad;
      end
    end
  end

  cmd_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (~cmd_enable),
    .push      (push),
    .push_data (mem_rsp_data),
    .pop       (pop),
    .pop_data  (cmd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef CMD_RING_STREAMER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cmd_count    <= '0;
      perf_stall_cycles <= '0;
    end else if (en_rise) begin
      perf_cmd_count    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (cmd_valid && cmd_ready)
        perf_cmd_count <= perf_cmd_count + 32'd1;
      if (cmd_valid && !cmd_ready)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_cmd_count    = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cmd_ring_streamer.sv
// tb_cmd_ring_streamer: table-driven ring configs plus corner sequences,
// with request/command scoreboards fed by a memory and dispatcher model.
module tb_cmd_ring_streamer;

  localparam logic [31:0] CB = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_enable = 1'b0;
  logic [31:0] cmd_ring_base = '0;
  logic [31:0] cmd_ring_size_bytes = '0;
  logic [31:0] cmd_cons_ptr_bytes = '0;
  logic [31:0] cmd_completion_base = CB;
  logic        doorbell_valid = 1'b0;
  logic [31:0] doorbell_prod_ptr = '0;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        busy;
  logic [31:0] cons_ptr_out;
  logic        err;
  logic [31:0] perf_cmd_count;
  logic [31:0] perf_stall_cycles;

  always #5 clk = ~clk;

  cmd_ring_streamer #(
    .FIFO_DEPTH (4),
    .ADDR_W     (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_enable          (cmd_enable),
    .cmd_ring_base       (cmd_ring_base),
    .cmd_ring_size_bytes (cmd_ring_size_bytes),
    .cmd_cons_ptr_bytes  (cmd_cons_ptr_bytes),
    .cmd_completion_base (cmd_completion_base),
    .doorbell_valid      (doorbell_valid),
    .doorbell_prod_ptr   (doorbell_prod_ptr),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_we          (mem_req_we),
    .mem_req_addr        (mem_req_addr),
    .mem_req_wdata       (mem_req_wdata),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_data            (cmd_data),
    .busy                (busy),
    .cons_ptr_out        (cons_ptr_out),
    .err                 (err),
    .perf_cmd_count      (perf_cmd_count),
    .perf_stall_cycles   (perf_stall_cycles)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] cons0;
    logic [31:0] prod;
    bit          exp_err;
    logic [31:0] exp_cons;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  req_t        exp_req[$];
  logic [31:0] exp_cmd[$];
  int          rsp_delay = 1;
  int          stall_left = 0;
  int          rd_acc = 0;
  int          stall_seen = 0;
  int          stall_obs = 0;
  bit          sink_ready = 1'b1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return 32'hA0 + ((a & 32'hFFF) >> 2);
  endfunction

  // memory: accepts at negedge-decided ready, replies after rsp_delay
  initial begin : responder
    int   rsp_cnt;
    logic [31:0] rsp_q;
    bit   pv;
    logic [31:0] pa;
    logic pw;
    req_t e;
    rsp_cnt = 0; rsp_q = '0; pv = 0; pa = '0; pw = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rsp_q;
        end
      end
      if (pv) begin
        chk("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("req_hold_addr", mem_req_addr, pa);
        chk("req_hold_we", {31'b0, mem_req_we}, {31'b0, pw});
      end
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      pv = mem_req_valid && !mem_req_ready;
      pa = mem_req_addr;
      pw = mem_req_we;
      if (pv) stall_seen++;
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req_addr", mem_req_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_req.pop_front();
          chk("req_we", {31'b0, mem_req_we}, {31'b0, e.we});
          chk("req_addr", mem_req_addr, e.addr);
          if (e.we) chk("req_wdata", mem_req_wdata, e.wdata);
        end
        if (!mem_req_we) begin
          rd_acc++;
          rsp_cnt = rsp_delay;
          rsp_q   = mem_model(mem_req_addr);
        end
      end
    end
  end

  // dispatcher: pops the expected-command queue on every handshake
  initial begin : consumer
    cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      cmd_ready = sink_ready;
      if (cmd_valid && !cmd_ready) stall_obs++;
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0)
          chk("unexpected_cmd", cmd_data, 32'hFFFF_FFFF);
        else
          chk("cmd_data", cmd_data, exp_cmd.pop_front());
      end
    end
  end

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_req.size() == 0 && exp_cmd.size() == 0
          && !busy) return;
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout req_left=%0d cmd_left=%0d busy=%0b",
             exp_req.size(), exp_cmd.size(), busy);
  endtask

  task automatic setup(input logic [31:0] b,
                       input logic [31:0] s,
                       input logic [31:0] c);
    cmd_enable = 1'b0;
    repeat (3) @(negedge clk);
    cmd_ring_base       = b;
    cmd_ring_size_bytes = s;
    cmd_cons_ptr_bytes  = c;
  endtask

  // expected traffic for a healthy ring walk from c to p
  task automatic expect_walk(input logic [31:0] b,
                             input logic [31:0] s,
                             input logic [31:0] c,
                             input logic [31:0] p);
    logic [31:0] q;
    int guard;
    q = c;
    guard = 0;
    while (q != p && guard < 64) begin
      exp_req.push_back('{1'b0, b + q, 32'h0});
      exp_cmd.push_back(mem_model(b + q));
      q = q + 32'd4;
      if (q == s) q = '0;
      guard++;
    end
    if (p != c) exp_req.push_back('{1'b1, CB, p});
  endtask

  task automatic enable_and_ring(input logic [31:0] p);
    stall_obs = 0;
    cmd_enable = 1'b1;
    repeat (2) @(negedge clk);
    doorbell_valid    = 1'b1;
    doorbell_prod_ptr = p;
    @(negedge clk);
    doorbell_valid = 1'b0;
  endtask

  task automatic disable_check(input string nm);
    cmd_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, "_off_err"}, {31'b0, err}, 32'd0);
    chk({nm, "_off_busy"}, {31'b0, busy}, 32'd0);
  endtask

  vec_t vt[9];

  initial begin : main
    vt[0] = '{32'h1000, 32'h20, 32'h00, 32'h0C, 1'b0, 32'h0C};
    vt[1] = '{32'h1000, 32'h20, 32'h18, 32'h08, 1'b0, 32'h08};
    vt[2] = '{32'h1000, 32'h22, 32'h00, 32'h04, 1'b1, 32'h00};
    vt[3] = '{32'h1000, 32'h20, 32'h00, 32'h40, 1'b1, 32'h00};
    vt[4] = '{32'h1002, 32'h20, 32'h00, 32'h04, 1'b1, 32'h00};
    vt[5] = '{32'h2000, 32'h10, 32'h10, 32'h04, 1'b1, 32'h00};
    vt[6] = '{32'h2000, 32'h10, 32'h04, 32'h04, 1'b0, 32'h04};
    vt[7] = '{32'h3000, 32'h10, 32'h08, 32'h04, 1'b0, 32'h04};
    vt[8] = '{32'h1000, 32'h20, 32'h00, 32'h06, 1'b1, 32'h00};

    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_req_we", {31'b0, mem_req_we}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_req_wdata", mem_req_wdata, 32'd0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_cmd_data", cmd_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cons", cons_ptr_out, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_perf_cnt", perf_cmd_count, 32'd0);
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      setup(vt[i].base, vt[i].size, vt[i].cons0);
      if (!vt[i].exp_err)
        expect_walk(vt[i].base, vt[i].size,
                    vt[i].cons0, vt[i].prod);
      enable_and_ring(vt[i].prod);
      if (!vt[i].exp_err) wait_drain(200);
      repeat (10) @(negedge clk);
      chk($sformatf("v%0d_err", i), {31'b0, err},
          {31'b0, vt[i].exp_err});
      if (!vt[i].exp_err)
        chk($sformatf("v%0d_cons", i), cons_ptr_out,
            vt[i].exp_cons);
      chk($sformatf("v%0d_req_left", i), exp_req.size(), 32'd0);
      chk($sformatf("v%0d_cmd_left", i), exp_cmd.size(), 32'd0);
      disable_check($sformatf("v%0d", i));
    end

    // backpressure: 8 pending words, depth-4 FIFO
    setup(32'h1000, 32'h40, 32'h00);
    expect_walk(32'h1000, 32'h40, 32'h00, 32'h20);
    sink_ready = 1'b0;
    rd_acc = 0;
    enable_and_ring(32'h20);
    repeat (30) @(negedge clk);
    chk("bp_reads", rd_acc, 32'd4);
    chk("bp_cmd_valid", {31'b0, cmd_valid}, 32'd1);
    chk("bp_head", cmd_data, 32'hA0);
    sink_ready = 1'b1;
    wait_drain(300);
    chk("bp_reads_total", rd_acc, 32'd8);
    chk("bp_cons", cons_ptr_out, 32'h20);
`ifdef CMD_RING_STREAMER_PERF_EN
    chk("bp_perf_stall", perf_stall_cycles, stall_obs);
    chk("bp_perf_cnt", perf_cmd_count, 32'd8);
`else
    chk("bp_perf_stall_off", perf_stall_cycles, 32'd0);
    chk("bp_perf_cnt_off", perf_cmd_count, 32'd0);
`endif
    disable_check("bp");

    // request held through 5 cycles of mem_req_ready low
    setup(32'h1000, 32'h20, 32'h00);
    expect_walk(32'h1000, 32'h20, 32'h00, 32'h04);
    rd_acc = 0;
    stall_seen = 0;
    stall_left = 5;
    enable_and_ring(32'h04);
    wait_drain(200);
    chk("hold_reads", rd_acc, 32'd1);
    chk("hold_stall_cycles", stall_seen, 32'd5);
    chk("hold_cons", cons_ptr_out, 32'h04);
    disable_check("hold");

    // disable while the read is outstanding
    setup(32'h1000, 32'h20, 32'h00);
    exp_req.push_back('{1'b0, 32'h1000, 32'h0});
    rd_acc = 0;
    rsp_delay = 4;
    enable_and_ring(32'h08);
    for (int i = 0; i < 50 && rd_acc == 0; i++)
      @(negedge clk);
    chk("dis_read_seen", rd_acc, 32'd1);
    cmd_enable = 1'b0;
    repeat (12) @(negedge clk);
    chk("dis_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("dis_busy", {31'b0, busy}, 32'd0);
    chk("dis_cons_hold", cons_ptr_out, 32'd0);
    chk("dis_reads", rd_acc, 32'd1);
    chk("dis_req_left", exp_req.size(), 32'd0);
    rsp_delay = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_ring_streamer.md
Name: cmd_ring_streamer

Overview:
Consumer end of the command ring configured through the compute unit's command-streamer CSRs (enable, ring base, ring size, consumer pointer, completion base). It fetches 32-bit command words from the memory ring between its consumer pointer and a doorbell-supplied producer pointer, and queues them to the dispatcher over a valid/ready interface. Whenever the ring drains, it writes the updated consumer pointer to the completion address.

Parameters:
FIFO_DEPTH, 4, command word FIFO entries (power of 2, >=2)
ADDR_W, 32, memory address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_enable  in  1  CSR config bit0
cmd_ring_base  in  32  ring base byte address
cmd_ring_size_bytes  in  32  ring size in bytes
cmd_cons_ptr_bytes  in  32  initial consumer offset, loaded on enable rise
cmd_completion_base  in  32  consumer-pointer writeback address
doorbell_valid  in  1  producer pointer update strobe
doorbell_prod_ptr  in  32  new producer byte offset
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write (writeback), 0 = read (fetch)
mem_req_addr  out  ADDR_W  byte address
mem_req_wdata  out  32  writeback data
mem_rsp_valid  in  1  read data valid (writes get no response)
mem_rsp_data  in  32  read data
cmd_valid  out  1  command word available
cmd_ready  in  1  dispatcher accepts
cmd_data  out  32  command word
busy  out  1  state != IDLE or FIFO non-empty
cons_ptr_out  out  32  current consumer offset
err  out  1  sticky config error
perf_cmd_count  out  32  commands delivered (optional feature)
perf_stall_cycles  out  32  cycles with cmd_valid && !cmd_ready (optional feature)

Behaviour:
- Reset values: all outputs 0. Internal state: cons=0, prod=0, last_wb=0, FSM=IDLE, FIFO empty.
- Enable rise (registered enable 0->1):
  - Load cons = prod = last_wb = cmd_cons_ptr_bytes.
  - Validate: base[1:0]==0, size!=0, size[1:0]==0, cons<size, cons[1:0]==0. Any failure -> ERROR.
- Doorbell: accepted only while enabled and not ERROR. Value >=size or [1:0]!=0 -> ERROR. Otherwise prod <= doorbell_prod_ptr.
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, WB_REQ, ERROR.
  - IDLE -> FETCH_REQ when enabled && cons!=prod && FIFO has a free slot.
  - IDLE -> WB_REQ when enabled && cons==prod && cons!=last_wb.
  - FETCH_REQ: mem_req_valid=1, we=0, addr=base+cons. On ready -> FETCH_WAIT.
  - FETCH_WAIT: on mem_rsp_valid, push data into the FIFO and set cons = (cons+4==size) ? 0 : cons+4. Then -> IDLE.
  - WB_REQ: valid=1, we=1, addr=completion_base, wdata=cons. On ready, last_wb=cons -> IDLE.
  - ERROR: err=1, no requests. Exits to IDLE only when enable goes low.
- Ordering: one outstanding read at most. Request signals are held stable until ready. Fetch has priority over writeback.
- FIFO slot rule: free slot is counted including the one in-flight read, so the FIFO never overflows.
- FIFO timing: first-word-fall-through. cmd_valid asserts the cycle after the response is pushed. Simultaneous push and pop on a full FIFO is legal.
- Disable (enable low mid-operation):
  - Outstanding request or response completes (the response is discarded), then -> IDLE.
  - FIFO flushed; err cleared.
  - cons_ptr_out holds its last value.
- Wrap: an offset equal to size-4 advances to 0. Ring full/empty is defined by the producer. cons==prod means empty.
- Doorbell arriving in the same cycle as a cons advance: both take effect.
- Async reset mid-transaction aborts immediately. Memory must tolerate a dropped request.

Optional Feature:
- Macro: CMD_RING_STREAMER_PERF_EN.
- Defined: perf_cmd_count increments on each cmd_valid&&cmd_ready; perf_stall_cycles increments on cmd_valid&&!cmd_ready. Both wrap at 2^32 and clear on enable rise.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Package cmd_ring_pkg: state enum, CMD_WORD_BYTES=4, alignment check constants.
- Sub-module cmd_word_fifo (FIFO_DEPTH x 32, FWFT, full/empty/count).

Test Plan:
- base=0x1000, size=0x20, cons=0, enable, doorbell prod=0x0C, memory returns 0xA0,0xA1,0xA2 -> reads at 0x1000/04/08, cmd_data A0,A1,A2 in order, then write 0x0C to completion_base.
- cons=0x18, size=0x20, doorbell prod=0x08 -> reads 0x1018,0x101C,0x1000,0x1004; cons_ptr_out=0x08.
- cmd_ready held 0, 8 commands pending, FIFO_DEPTH=4 -> exactly 4 reads issued, then stall. Releasing ready resumes; perf_stall_cycles counts the stall cycles (PERF_EN).
- size=0x22 on enable rise -> err=1, no mem_req_valid. Enable low -> err=0, busy=0.
- Doorbell prod=0x40 with size=0x20 -> ERROR. Enable low during FETCH_WAIT on a valid ring -> response dropped, FIFO empty, no writeback.
- mem_req_ready low for 5 cycles during fetch -> valid/addr stable throughout, single request accepted.
